regfile_writeback_arbiter: RTL and testbench

Shares the register file's single write port (rd, rdWriteEnable, rdAddress) between NUM_SOURCES writeback producers (source 0 execute, 1 load unit, 2 CSR/debug) with round-robin arbitration and a registered output stage. It also keeps a 32-entry busy scoreboard of destination registers with writes in flight, so the decode/issue stage can detect read-after-write hazards on rs1/rs2. It sits between the functional units and the register file.

---
 rtl/regfile_writeback_arbiter_if.sv | 36 +++
 rtl/regfile_writeback_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus between the functional-unit producers and the register file
// write port. The master side drives requests and observes grants/writes; the
// slave side is the arbiter.
interface regfile_writeback_arbiter_if #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5
);
  logic [NUM_SOURCES-1:0]            req_valid;
  logic [NUM_SOURCES-1:0]            req_ready;
  logic [NUM_SOURCES*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_SOURCES*DATA_WIDTH-1:0] req_data;
  logic                              rf_write_enable;
  logic [ADDR_WIDTH-1:0]             rf_write_address;
  logic [DATA_WIDTH-1:0]             rf_write_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  rf_write_enable,
    input  rf_write_address,
    input  rf_write_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output rf_write_enable,
    output rf_write_address,
    output rf_write_data
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among the
// writeback producers, with a registered write stage and a busy scoreboard of
// destination registers that still have a write in flight.
module regfile_writeback_arbiter #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_writeback_arbiter_if.slave bus,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_address,
  input  logic [ADDR_WIDTH-1:0] rs2_address,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [31:0]           busy_mask,
  output logic                  overlap_error
);

  localparam int PTR_W = $clog2(NUM_SOURCES);

  // Round-robin pointer: the source searched first this cycle.
  logic [PTR_W-1:0] ptr_reg, ptr_next;

  // Per-source views of the packed request buses.
  logic [ADDR_WIDTH-1:0] src_addr [NUM_SOURCES];
  logic [DATA_WIDTH-1:0] src_data [NUM_SOURCES];

  // Requests seen by the arbiter; forced off while reset is held so no
  // grant leaks out during reset.
  logic [NUM_SOURCES-1:0] valid_eff;
  // Requests at or above the pointer; they win over wrapped-around ones.
  logic [NUM_SOURCES-1:0] hi_req;

  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;

  // Registered write stage.
  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;

  // Scoreboard state.
  logic [31:0] busy_reg, busy_next;
  logic [31:0] reserve_hot, clear_hot;
  logic        overlap_reg, overlap_next;

  assign valid_eff = reset ? bus.req_valid : '0;

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign src_addr[gi]      = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign src_data[gi]      = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign hi_req[gi]        = valid_eff[gi] && (PTR_W'(gi) >= ptr_reg);
      assign bus.req_ready[gi] = grant_found && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  // Rotating priority: lowest requester at/after the pointer, otherwise the
  // lowest requester overall (the search has wrapped past the last source).
  always_comb begin
    grant_found = |valid_eff;
    grant_idx   = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (valid_eff[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
    if (|hi_req) begin
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
        if (hi_req[i]) begin
          grant_idx = PTR_W'(i);
        end
      end
    end
  end

  // Granted payload and the pointer update that follows the winner.
  always_comb begin
    grant_addr = src_addr[grant_idx];
    grant_data = src_data[grant_idx];
    ptr_next   = ptr_reg;
    if (grant_found) begin
      if (grant_idx == PTR_W'(NUM_SOURCES - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + 1'b1;
      end
    end
  end

  // Write stage: load on a grant, x0 writes are consumed but never enabled;
  // without a grant the enable drops and address/data hold.
  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    if (grant_found) begin
      wr_en_next   = (grant_addr != '0);
      wr_addr_next = grant_addr;
      wr_data_next = grant_data;
    end
  end

  // Scoreboard: a reservation sets, a grant clears; a same-cycle reservation
  // of the granted register wins because a new producer is now in flight.
  always_comb begin
    reserve_hot  = reserve_valid ? (32'd1 << reserve_addr) : 32'd0;
    clear_hot    = grant_found ? (32'd1 << grant_addr) : 32'd0;
    busy_next    = ((busy_reg & ~clear_hot) | reserve_hot) & ~32'd1;
    overlap_next = overlap_reg;
    if (reserve_valid && (reserve_addr != '0) && busy_reg[reserve_addr] &&
        !(grant_found && (grant_addr == reserve_addr))) begin
      overlap_next = 1'b1;
    end
  end

  // Pointer and write-stage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Scoreboard registers; the overlap flag is sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg    <= '0;
      overlap_reg <= 1'b0;
    end else begin
      busy_reg    <= busy_next;
      overlap_reg <= overlap_next;
    end
  end

  assign bus.rf_write_enable  = wr_en_reg;
  assign bus.rf_write_address = wr_addr_reg;
  assign bus.rf_write_data    = wr_data_reg;

  assign busy_mask     = busy_reg;
  assign overlap_error = overlap_reg;
  // Registered state only: a grant in this cycle is not bypassed.
  assign rs1_busy      = busy_reg[rs1_address];
  assign rs2_busy      = busy_reg[rs2_address];

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench: a table of hand-derived vectors, hand-written
// round-robin and async-reset sequences, then random traffic against a
// behavioural model.
module tb_regfile_writeback_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_writeback_arbiter_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          reserve_valid = 1'b0;
  logic [AW-1:0] reserve_addr  = '0;
  logic [AW-1:0] rs1_address   = '0;
  logic [AW-1:0] rs2_address   = '0;
  logic          rs1_busy, rs2_busy;
  logic [31:0]   busy_mask;
  logic          overlap_error;

  regfile_writeback_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .rs1_address   (rs1_address),
    .rs2_address   (rs2_address),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .busy_mask     (busy_mask),
    .overlap_error (overlap_error)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        rv;
    logic [4:0]  ra, rs1, rs2;
    logic [2:0]  ready;
    logic        rs1b, rs2b;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic [2:0] valid, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic rv, input logic [4:0] ra,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.req_valid = valid;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
    reserve_valid = rv;
    reserve_addr  = ra;
    rs1_address   = r1;
    rs2_address   = r2;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"},   64'(bus.rf_write_enable), 64'd0);
    check({tag, "_addr"}, 64'(bus.rf_write_address), 64'd0);
    check({tag, "_data"}, 64'(bus.rf_write_data), 64'd0);
    check({tag, "_busy"}, 64'(busy_mask), 64'd0);
    check({tag, "_ovf"},  64'(overlap_error), 64'd0);
  endtask

  // Held in reset for two edges with every source requesting: no grant, all clear.
  task automatic do_reset();
    reset = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b1, 5'd4, 5'd0, 5'd0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    check_outputs_zero("reset");
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
  endtask

  // Behavioural model state for the random phase.
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_ovf, m_en;
  bit [4:0]    m_addr;
  bit [31:0]   m_data;

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // valid a0 a1 a2 d0 d1 d2 rv ra rs1 rs2 | ready rs1b rs2b | en waddr wdata busy ovf
    vecs[0]  = '{3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b010, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b000, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[2]  = '{3'b001, 5'd0, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h0, 1'b0};
    vecs[3]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0,
                 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h20, 1'b0};
    vecs[4]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h20, 1'b0};
    vecs[5]  = '{3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hAAAA0005, 1'b0, 5'd0, 5'd5, 5'd5,
                 3'b100, 1'b1, 1'b1, 1'b1, 5'd5, 32'hAAAA0005, 32'h0, 1'b0};
    vecs[6]  = '{3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hBBBB0005, 1'b1, 5'd5, 5'd5, 5'd0,
                 3'b100, 1'b0, 1'b0, 1'b1, 5'd5, 32'hBBBB0005, 32'h20, 1'b0};
    vecs[7]  = '{3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hCCCC0005, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0,
                 3'b010, 1'b1, 1'b0, 1'b1, 5'd5, 32'hCCCC0005, 32'h20, 1'b0};
    vecs[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0,
                 3'b000, 1'b0, 1'b0, 1'b0, 5'd5, 32'hCCCC0005, 32'h220, 1'b0};
    vecs[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd5,
                 3'b000, 1'b1, 1'b1, 1'b0, 5'd5, 32'hCCCC0005, 32'h220, 1'b1};
    vecs[10] = '{3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                 3'b001, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 32'h20, 1'b1};
    vecs[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd5, 5'd9,
                 3'b000, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h20, 1'b1};
    vecs[12] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'd2, 5'd5,
                 3'b010, 1'b0, 1'b1, 1'b1, 5'd2, 32'h2, 32'h20, 1'b1};
    vecs[13] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b100, 1'b0, 1'b0, 1'b1, 5'd3, 32'h3, 32'h20, 1'b1};
    vecs[14] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b001, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1, 32'h20, 1'b1};

    // ---- Table-driven vectors ----
    do_reset();
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].valid, vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].d0, vecs[v].d1,
            vecs[v].d2, vecs[v].rv, vecs[v].ra, vecs[v].rs1, vecs[v].rs2);
      #1;
      check($sformatf("vec%0d_ready", v), 64'(bus.req_ready), 64'(vecs[v].ready));
      check($sformatf("vec%0d_rs1b", v), 64'(rs1_busy), 64'(vecs[v].rs1b));
      check($sformatf("vec%0d_rs2b", v), 64'(rs2_busy), 64'(vecs[v].rs2b));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_en", v), 64'(bus.rf_write_enable), 64'(vecs[v].en));
      check($sformatf("vec%0d_waddr", v), 64'(bus.rf_write_address), 64'(vecs[v].waddr));
      check($sformatf("vec%0d_wdata", v), 64'(bus.rf_write_data), 64'(vecs[v].wdata));
      check($sformatf("vec%0d_busy", v), 64'(busy_mask), 64'(vecs[v].busy));
      check($sformatf("vec%0d_ovf", v), 64'(overlap_error), 64'(vecs[v].ovf));
      $display("[TB] vec %0d: ready=%b en=%0d addr=%0d data=%h busy=%h ovf=%0d", v,
               vecs[v].ready, bus.rf_write_enable, bus.rf_write_address, bus.rf_write_data,
               busy_mask, overlap_error);
    end
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clock);
    #1;
    check("after_table_en", 64'(bus.rf_write_enable), 64'd0);

    // ---- Round-robin from reset with all sources continuously valid ----
    do_reset();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h101, 32'h102, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr%0d_ready", c), 64'(bus.req_ready), 64'(1 << (c % 3)));
      @(posedge clock);
      #1;
      check($sformatf("rr%0d_en", c), 64'(bus.rf_write_enable), 64'd1);
      check($sformatf("rr%0d_waddr", c), 64'(bus.rf_write_address), 64'((c % 3) + 1));
      check($sformatf("rr%0d_wdata", c), 64'(bus.rf_write_data), 64'(32'h100 + (c % 3)));
      $display("[TB] rr %0d: granted source %0d, wrote x%0d", c, c % 3, bus.rf_write_address);
    end

    // ---- Async reset in the middle of a write ----
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    repeat (2) @(posedge clock);
    #1;
    check("ar_ovf_pre", 64'(overlap_error), 64'd1);
    drive(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h44, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clock);
    #1;
    check("ar_en_pre", 64'(bus.rf_write_enable), 64'd1);
    check("ar_busy_pre", 64'(busy_mask), 64'h200);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("ar");
    check("ar_ready", 64'(bus.req_ready), 64'd0);
    $display("[TB] async reset mid-write: en=%0d busy=%h ovf=%0d", bus.rf_write_enable,
             busy_mask, overlap_error);
    @(posedge clock);
    #1;
    check("ar_hold_en", 64'(bus.rf_write_enable), 64'd0);
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    #1;
    check("ar_release_ready", 64'(bus.req_ready), 64'b001);

    // ---- Random traffic against the behavioural model ----
    do_reset();
    m_ptr = 0; m_busy = '0; m_ovf = 0; m_en = 0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      logic [2:0]  valid;
      logic [4:0]  a [3];
      logic [31:0] d [3];
      logic        rv;
      logic [4:0]  ra, r1, r2;
      int          g;
      valid = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        a[s] = 5'($urandom_range(0, 9));
        d[s] = $urandom;
      end
      rv = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 9));
      r1 = 5'($urandom_range(0, 9));
      r2 = 5'($urandom_range(0, 9));
      drive(valid, a[0], a[1], a[2], d[0], d[1], d[2], rv, ra, r1, r2);

      // Winner: first valid source walking from the pointer, wrapping around.
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      #1;
      check($sformatf("rnd%0d_ready", c), 64'(bus.req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      check($sformatf("rnd%0d_rs1b", c), 64'(rs1_busy), 64'(m_busy[r1]));
      check($sformatf("rnd%0d_rs2b", c), 64'(rs2_busy), 64'(m_busy[r2]));

      if (rv && ra != 0 && m_busy[ra] && !(g >= 0 && a[g] == ra)) m_ovf = 1;
      if (g >= 0) begin
        m_en   = (a[g] != 0);
        m_addr = a[g];
        m_data = d[g];
        m_ptr  = (g + 1) % N;
        m_busy[a[g]] = 1'b0;
      end else begin
        m_en = 0;
      end
      if (rv) m_busy[ra] = 1'b1;
      m_busy[0] = 1'b0;

      @(posedge clock);
      #1;
      check($sformatf("rnd%0d_en", c), 64'(bus.rf_write_enable), 64'(m_en));
      check($sformatf("rnd%0d_waddr", c), 64'(bus.rf_write_address), 64'(m_addr));
      check($sformatf("rnd%0d_wdata", c), 64'(bus.rf_write_data), 64'(m_data));
      check($sformatf("rnd%0d_busy", c), 64'(busy_mask), 64'(m_busy));
      check($sformatf("rnd%0d_ovf", c), 64'(overlap_error), 64'(m_ovf));
      $display("[TB] rnd %0d: valid=%b grant=%0d en=%0d addr=%0d busy=%h ovf=%0d", c, valid, g,
               m_en, m_addr, m_busy, m_ovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
